// File: rtl/data_memory_sized_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_sized_pkg
// Shared definitions for the sized data memory and its load-extension helper:
//   - RISC-V load/store funct3 size/sign codes
//   - controller state encoding
//   - access size in bytes for a funct3 code
// -----------------------------------------------------------------------------
package data_memory_sized_pkg;

    typedef logic [2:0] funct3_t;

    localparam funct3_t F3_B  = 3'b000;
    localparam funct3_t F3_H  = 3'b001;
    localparam funct3_t F3_W  = 3'b010;
    localparam funct3_t F3_D  = 3'b011;
    localparam funct3_t F3_BU = 3'b100;
    localparam funct3_t F3_HU = 3'b101;
    localparam funct3_t F3_WU = 3'b110;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Low two bits encode the size for every load/store code; bit 2 is the
    // unsigned flag and does not change the width.
    function automatic logic [3:0] size_bytes(input funct3_t f3);
        unique case (f3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_sized_if.sv
// -----------------------------------------------------------------------------
// data_memory_sized_if
// Request/response bus between a pipeline stage (master) and the data memory
// (slave).
//   req_valid/req_ready : request handshake, transfer when both high at clk
//   req_write           : 1 = store, 0 = load
//   req_funct3          : RISC-V size/sign code
//   req_addr/req_wdata  : byte address and store data
//   rsp_valid           : one-cycle response pulse, always accepted
//   rsp_rdata/rsp_error : extended load data / access rejected
// -----------------------------------------------------------------------------
interface data_memory_sized_if
    import data_memory_sized_pkg::*;
#(
    parameter int XLEN = 64
) ();

    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    funct3_t         req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/data_memory_sized_mem_load_extend.sv
// -----------------------------------------------------------------------------
// mem_load_extend
// Combinational byte-lane select and sign/zero extension of a load.
//   word     : XLEN-bit aligned word holding the addressed bytes
//   byte_off : byte offset of the access inside that word
//   funct3   : load size/sign code; 111 yields 0
//   data     : right-justified, extended load result
// -----------------------------------------------------------------------------
module mem_load_extend
    import data_memory_sized_pkg::*;
#(
    parameter  int XLEN  = 64,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  word,
    input  logic [OFF_W-1:0] byte_off,
    input  funct3_t          funct3,
    output logic [XLEN-1:0]  data
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            top;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        shifted = word >> {byte_off, 3'b000};
        mask    = '0;
        top     = 1'b0;
        unique case (funct3[1:0])
            2'b00: begin mask = XLEN'(64'h0000_0000_0000_00FF); top = shifted[7];  end
            2'b01: begin mask = XLEN'(64'h0000_0000_0000_FFFF); top = shifted[15]; end
            2'b10: begin mask = XLEN'(64'h0000_0000_FFFF_FFFF); top = shifted[31]; end
            default: begin mask = '1; top = 1'b0; end
        endcase
        data = shifted & mask;
        // funct3[2] clear = signed: fill everything above the field with its top bit.
        if (!funct3[2] && top) begin
            data = data | ~mask;
        end
        if (funct3 == 3'b111) begin
            data = '0;
        end
    end

endmodule

// File: rtl/data_memory_sized.sv
// -----------------------------------------------------------------------------
// data_memory_sized
// Byte-addressed little-endian data memory with a request/response bus, RV64
// access sizes, error flagging, post-reset zero clear and observation taps.
//   clk     : clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : data_memory_sized_if.slave request/response bus
//   busy    : high while the array is being zero-cleared after reset
//   taps    : tap k = XLEN-bit LE word at TAP_BASE + k*XLEN/8
// -----------------------------------------------------------------------------
module data_memory_sized
    import data_memory_sized_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int DEPTH_BYTES  = 1024,
    parameter int READ_LATENCY = 1,
    parameter int NUM_TAPS     = 6,
    parameter int TAP_BASE     = 256
) (
    input  logic                     clk,
    input  logic                     reset_n,
    data_memory_sized_if.slave       bus,
    output logic                     busy,
    output logic [NUM_TAPS*XLEN-1:0] taps
);

    localparam int WB        = XLEN / 8;
    localparam int OFF_W     = $clog2(WB);
    localparam int NUM_WORDS = DEPTH_BYTES / WB;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam int TAP_WORD  = TAP_BASE / WB;

    logic [XLEN-1:0] mem [NUM_WORDS];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q;
    logic [2:0]       lat_cnt_q;
    logic [XLEN-1:0]  pend_data_q;
    logic             pend_err_q;
    logic             rsp_valid_q;
    logic [XLEN-1:0]  rsp_rdata_q;
    logic             rsp_error_q;
    logic             req_ready_c;

    // ---------------- request decode ----------------
    funct3_t          f3;
    logic [3:0]       acc_size;
    logic [XLEN:0]    end_addr;
    logic             illegal, misaligned, out_of_range, req_err;
    logic             accept, is_load_ok, store_en;
    logic [IDX_W-1:0] word_idx;
    logic [OFF_W-1:0] byte_off;
    logic [WB-1:0]    be;
    logic [XLEN-1:0]  wdata_lane;
    logic [XLEN-1:0]  rd_word;
    logic [XLEN-1:0]  ld_data;

    assign f3       = bus.req_funct3;
    assign acc_size = size_bytes(f3);
    assign word_idx = bus.req_addr[OFF_W +: IDX_W];
    assign byte_off = bus.req_addr[OFF_W-1:0];

    always_comb begin
        illegal = bus.req_write ? f3[2] : (f3 == 3'b111);
        if (XLEN == 32 && (f3 == F3_D || f3 == F3_WU)) begin
            illegal = 1'b1;
        end
        misaligned   = (bus.req_addr[3:0] & (acc_size - 4'd1)) != 4'd0;
        // One extra bit so addr+size cannot wrap past the top of the space.
        end_addr     = {1'b0, bus.req_addr} + (XLEN+1)'(acc_size);
        out_of_range = end_addr > (XLEN+1)'(DEPTH_BYTES);
        req_err      = illegal | misaligned | out_of_range;
    end

    assign accept     = req_ready_c && bus.req_valid;
    assign is_load_ok = !bus.req_write && !req_err;
    assign store_en   = accept && bus.req_write && !req_err;
    assign be         = WB'((16'd1 << acc_size) - 16'd1) << byte_off;
    assign wdata_lane = bus.req_wdata << {byte_off, 3'b000};
    assign rd_word    = mem[word_idx];

    mem_load_extend #(.XLEN(XLEN)) u_load_extend (
        .word     (rd_word),
        .byte_off (byte_off),
        .funct3   (f3),
        .data     (ld_data)
    );

    // ---------------- storage ----------------
    // NOTE: the array has no reset term; it is zeroed word by word in CLEAR,
    // which keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (store_en) begin
            for (int b = 0; b < WB; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_taps
        assign taps[k*XLEN +: XLEN] = mem[IDX_W'(TAP_WORD + k)];
    end

    // ---------------- control FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_c = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            CLEAR: begin
                busy = 1'b1;
                if (clr_cnt_q == IDX_W'(NUM_WORDS - 1)) state_d = IDLE;
            end
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) state_d = WAIT;
            end
            WAIT: begin
                // Leave on the response edge so the next request can be
                // taken in the response cycle.
                if (lat_cnt_q == 3'd1) state_d = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end

    // ---------------- datapath / response ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt_q   <= '0;
            lat_cnt_q   <= '0;
            pend_data_q <= '0;
            pend_err_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            if (state_q == CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
            if (accept) begin
                // Load data is captured here, so later stores cannot alter it.
                lat_cnt_q   <= is_load_ok ? 3'(READ_LATENCY) : 3'd1;
                pend_data_q <= is_load_ok ? ld_data : '0;
                pend_err_q  <= req_err;
            end else if (state_q == WAIT) begin
                lat_cnt_q <= lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= pend_data_q;
                    rsp_error_q <= pend_err_q;
                end
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule
